// File: rtl/sw_pkg.sv
// sw_pkg: shared types and constants for the stopwatch mode controller.
//   sw_state_t - controller state encoding (IDLE, RUN, PAUSED, ADJUST)
//   BLANK_*    - per-digit blank masks, bit3..0 = min-tens, min-ones, sec-tens, sec-ones
package sw_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2,
      ADJUST = 2'd3
   } sw_state_t;

   localparam logic [3:0] BLANK_SEC  = 4'b0011;
   localparam logic [3:0] BLANK_MIN  = 4'b1100;
   localparam logic [3:0] BLANK_NONE = 4'b0000;

endpackage

// File: rtl/sw_debounce.sv
// sw_debounce: conditions one raw asynchronous input.
//   2-flop synchroniser, then a debouncer that adopts the synchronised value only after it
//   has differed from the debounced value for DEB_CYCLES consecutive cycles, then a
//   registered rising-edge pulse.
// Ports:
//   clk     - system clock
//   RESET_N - asynchronous active-low reset
//   din     - raw input (asynchronous)
//   dout    - debounced level
//   rise    - one-cycle pulse on a debounced 0->1 change
module sw_debounce
   import sw_pkg::*;
#(
   parameter int DEB_CYCLES = 65536,
   parameter int DEB_W      = $clog2(DEB_CYCLES + 1)
) (
   input  logic clk,
   input  logic RESET_N,
   input  logic din,
   output logic dout,
   output logic rise
);

   logic             sync1;
   logic             sync2;
   logic             deb;
   logic             rise_r;
   logic [DEB_W-1:0] cnt;

   always_ff @(posedge clk or negedge RESET_N) begin
      if (!RESET_N) begin
         sync1  <= 1'b0;
         sync2  <= 1'b0;
         deb    <= 1'b0;
         rise_r <= 1'b0;
         cnt    <= '0;
      end else begin
         sync1  <= din;
         sync2  <= sync1;
         rise_r <= 1'b0;
         if (sync2 != deb) begin
            if (cnt == DEB_W'(DEB_CYCLES - 1)) begin
               deb    <= sync2;
               cnt    <= '0;
               // Pulse is registered together with the level change.
               rise_r <= sync2;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            // Any bounce back to the settled value restarts the count.
            cnt <= '0;
         end
      end
   end

   assign dout = deb;
   assign rise = rise_r;

endmodule

// File: rtl/sw_ctrl.sv
// sw_ctrl: stopwatch mode controller.
//   Conditions the buttons/switches, runs the IDLE/RUN/PAUSED/ADJUST state machine and
//   issues registered single-cycle clear/increment enables plus a display blank mask.
// Ports:
//   clk, RESET_N          - clock, asynchronous active-low reset
//   btn_reset, btn_pause  - raw buttons (active-high)
//   sw_adj, sw_sel        - raw switches (adjust mode; 1 = seconds, 0 = minutes)
//   tick_1hz, tick_2hz    - single-cycle enables from the divider
//   blink_phase           - 1 = blanked blink phase
//   cnt_clr               - clear all digits
//   cnt_inc_sec/_min      - increment seconds / minutes field
//   cnt_carry_en          - seconds wrap carries into minutes
//   blank_mask            - per-digit blank, bit3..0 = min-tens, min-ones, sec-tens, sec-ones
//   state_o               - current state
// Optional feature macro SW_CTRL_LAP_EN: adds btn_lap input and lap_hold output.
module sw_ctrl
   import sw_pkg::*;
#(
   parameter int DEB_CYCLES = 65536,
   parameter int DEB_W      = $clog2(DEB_CYCLES + 1)
) (
   input  logic       clk,
   input  logic       RESET_N,
   input  logic       btn_reset,
   input  logic       btn_pause,
   input  logic       sw_adj,
   input  logic       sw_sel,
   input  logic       tick_1hz,
   input  logic       tick_2hz,
   input  logic       blink_phase,
`ifdef SW_CTRL_LAP_EN
   input  logic       btn_lap,
   output logic       lap_hold,
`endif
   output logic       cnt_clr,
   output logic       cnt_inc_sec,
   output logic       cnt_inc_min,
   output logic       cnt_carry_en,
   output logic [3:0] blank_mask,
   output logic [1:0] state_o
);

   logic rst_deb, rst_p;
   logic pause_deb, pause_p;
   logic adj_deb, adj_rise;
   logic sel_deb, sel_rise;

   sw_debounce #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb_rst (
      .clk     (clk),
      .RESET_N (RESET_N),
      .din     (btn_reset),
      .dout    (rst_deb),
      .rise    (rst_p)
   );

   sw_debounce #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb_pause (
      .clk     (clk),
      .RESET_N (RESET_N),
      .din     (btn_pause),
      .dout    (pause_deb),
      .rise    (pause_p)
   );

   sw_debounce #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb_adj (
      .clk     (clk),
      .RESET_N (RESET_N),
      .din     (sw_adj),
      .dout    (adj_deb),
      .rise    (adj_rise)
   );

   sw_debounce #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb_sel (
      .clk     (clk),
      .RESET_N (RESET_N),
      .din     (sw_sel),
      .dout    (sel_deb),
      .rise    (sel_rise)
   );

   // Buttons act on edges, switches on levels; the other halves are not needed.
   logic unused_deb;
   assign unused_deb = ^{rst_deb, pause_deb, adj_rise, sel_rise};

   sw_state_t  state, state_nxt;
   logic       clr_nxt, inc_sec_nxt, inc_min_nxt, carry_nxt;
   logic [3:0] blank_nxt;

   // Next-state, in priority order: reset press, adjust entry, adjust exit, pause press.
   always_comb begin
      state_nxt = state;
      if (rst_p) begin
         state_nxt = adj_deb ? ADJUST : IDLE;
      end else if (adj_deb && (state != ADJUST)) begin
         state_nxt = ADJUST;
      end else if ((state == ADJUST) && !adj_deb) begin
         state_nxt = PAUSED;
      end else if (pause_p) begin
         case (state)
            IDLE:    state_nxt = RUN;
            RUN:     state_nxt = PAUSED;
            PAUSED:  state_nxt = RUN;
            default: state_nxt = state;
         endcase
      end
   end

   // Outputs decode the pre-transition state; a reset press suppresses increments.
   always_comb begin
      clr_nxt     = rst_p;
      inc_sec_nxt = 1'b0;
      inc_min_nxt = 1'b0;
      carry_nxt   = 1'b0;
      blank_nxt   = BLANK_NONE;
      case (state)
         RUN: begin
            inc_sec_nxt = tick_1hz & ~rst_p;
            carry_nxt   = 1'b1;
         end
         ADJUST: begin
            inc_sec_nxt = tick_2hz & sel_deb & ~rst_p;
            inc_min_nxt = tick_2hz & ~sel_deb & ~rst_p;
            if (blink_phase) begin
               blank_nxt = sel_deb ? BLANK_SEC : BLANK_MIN;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge RESET_N) begin
      if (!RESET_N) begin
         state        <= IDLE;
         cnt_clr      <= 1'b0;
         cnt_inc_sec  <= 1'b0;
         cnt_inc_min  <= 1'b0;
         cnt_carry_en <= 1'b0;
         blank_mask   <= BLANK_NONE;
      end else begin
         state        <= state_nxt;
         cnt_clr      <= clr_nxt;
         cnt_inc_sec  <= inc_sec_nxt;
         cnt_inc_min  <= inc_min_nxt;
         cnt_carry_en <= carry_nxt;
         blank_mask   <= blank_nxt;
      end
   end

   assign state_o = state;

`ifdef SW_CTRL_LAP_EN
   logic lap_deb, lap_p;

   sw_debounce #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb_lap (
      .clk     (clk),
      .RESET_N (RESET_N),
      .din     (btn_lap),
      .dout    (lap_deb),
      .rise    (lap_p)
   );

   logic unused_lap;
   assign unused_lap = lap_deb;

   always_ff @(posedge clk or negedge RESET_N) begin
      if (!RESET_N) begin
         lap_hold <= 1'b0;
      end else if (rst_p || (state_nxt != RUN)) begin
         lap_hold <= 1'b0;
      end else if ((state == RUN) && lap_p) begin
         lap_hold <= ~lap_hold;
      end
   end
`endif

endmodule

// File: tb/tb_sw_ctrl.sv
// tb_sw_ctrl: directed scenarios plus randomized stimulus for sw_ctrl (DEB_CYCLES = 4),
// checked every cycle against a behavioural model of the controller.
module tb_sw_ctrl;

   localparam int DEB = 4;

   logic       clk = 1'b0;
   logic       RESET_N = 1'b0;
   logic       btn_reset = 1'b0, btn_pause = 1'b0, sw_adj = 1'b0, sw_sel = 1'b0;
   logic       tick_1hz = 1'b0, tick_2hz = 1'b0, blink_phase = 1'b0;
   logic       cnt_clr, cnt_inc_sec, cnt_inc_min, cnt_carry_en;
   logic [3:0] blank_mask;
   logic [1:0] state_o;

   sw_ctrl #(.DEB_CYCLES(DEB)) dut (
      .clk          (clk),
      .RESET_N      (RESET_N),
      .btn_reset    (btn_reset),
      .btn_pause    (btn_pause),
      .sw_adj       (sw_adj),
      .sw_sel       (sw_sel),
      .tick_1hz     (tick_1hz),
      .tick_2hz     (tick_2hz),
      .blink_phase  (blink_phase),
      .cnt_clr      (cnt_clr),
      .cnt_inc_sec  (cnt_inc_sec),
      .cnt_inc_min  (cnt_inc_min),
      .cnt_carry_en (cnt_carry_en),
      .blank_mask   (blank_mask),
      .state_o      (state_o)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // Model: per input (0 reset, 1 pause, 2 adj, 3 sel) the raw value seen one and two
   // clocks ago, the debounced level, the length of the current disagreement run and
   // the pending press pulse. Controller state as an int 0..3.
   bit m_h1[4], m_h2[4], m_deb[4], m_rise[4];
   int m_run[4];
   int m_st;
   bit m_clr, m_isec, m_imin, m_carry;
   bit [3:0] m_blank;

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_h1[i] = 0; m_h2[i] = 0; m_deb[i] = 0; m_rise[i] = 0; m_run[i] = 0;
      end
      m_st = 0; m_clr = 0; m_isec = 0; m_imin = 0; m_carry = 0; m_blank = 4'h0;
   endtask

   // Advance the model by one clock using the current inputs.
   task automatic model_step();
      bit raw[4];
      bit rp, pp, adj, sel, s;
      int nst;
      raw[0] = btn_reset; raw[1] = btn_pause; raw[2] = sw_adj; raw[3] = sw_sel;
      rp = m_rise[0]; pp = m_rise[1]; adj = m_deb[2]; sel = m_deb[3];

      m_clr   = rp;
      m_isec  = !rp && ((m_st == 1 && tick_1hz) || (m_st == 3 && sel && tick_2hz));
      m_imin  = !rp && m_st == 3 && !sel && tick_2hz;
      m_carry = (m_st == 1);
      m_blank = (m_st == 3 && blink_phase) ? (sel ? 4'b0011 : 4'b1100) : 4'b0000;

      nst = m_st;
      if (rp) nst = adj ? 3 : 0;
      else if (adj && m_st != 3) nst = 3;
      else if (m_st == 3 && !adj) nst = 2;
      else if (pp) nst = (m_st == 0) ? 1 : (m_st == 1) ? 2 : (m_st == 2) ? 1 : m_st;
      m_st = nst;

      for (int i = 0; i < 4; i++) begin
         s = m_h2[i];
         m_rise[i] = 0;
         if (s != m_deb[i]) begin
            m_run[i]++;
            if (m_run[i] == DEB) begin
               m_deb[i] = s;
               m_rise[i] = s;
               m_run[i] = 0;
            end
         end else begin
            m_run[i] = 0;
         end
         m_h2[i] = m_h1[i];
         m_h1[i] = raw[i];
      end
   endtask

   task automatic cyc();
      model_step();
      @(posedge clk);
      #1;
      check("state", {2'b00, state_o}, 4'(m_st));
      check("cnt_clr", {3'b0, cnt_clr}, {3'b0, m_clr});
      check("inc_sec", {3'b0, cnt_inc_sec}, {3'b0, m_isec});
      check("inc_min", {3'b0, cnt_inc_min}, {3'b0, m_imin});
      check("carry_en", {3'b0, cnt_carry_en}, {3'b0, m_carry});
      check("blank", blank_mask, m_blank);
      check("inc_excl", {3'b0, cnt_inc_sec & cnt_inc_min}, 4'h0);
   endtask

   task automatic rnd_ticks();
      tick_1hz    = ($urandom_range(0, 3) == 0);
      tick_2hz    = ($urandom_range(0, 2) == 0);
      blink_phase = ($urandom_range(0, 7) == 0) ? ~blink_phase : blink_phase;
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) begin
         rnd_ticks();
         cyc();
      end
   endtask

   task automatic press_pause();
      btn_pause = 1'b1;
      run(8);
      btn_pause = 1'b0;
      run(8);
   endtask

   int  lat;
   bit  hit;

   initial begin
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("reset_state", {2'b00, state_o}, 4'h0);
      check("reset_blank", blank_mask, 4'h0);
      @(negedge clk);
      RESET_N = 1'b1;

      // Idle with ticks toggling: nothing may happen.
      run(100);

      // Press latency from IDLE: state must read RUN 7 cycles after the raw edge.
      lat = 0;
      for (int k = 1; k <= 12; k++) begin
         btn_pause = (k <= 8);
         tick_1hz = 1'b0; tick_2hz = 1'b0;
         cyc();
         if (lat == 0 && state_o == 2'd1) lat = k;
      end
      btn_pause = 1'b0;
      check("press_latency", 4'(lat), 4'd7);
      run(30);

      // A 3-cycle glitch is filtered out.
      btn_pause = 1'b1;
      run(3);
      btn_pause = 1'b0;
      run(15);
      check("glitch_run", {2'b00, state_o}, 4'd1);

      // RUN -> PAUSED -> RUN.
      press_pause();
      run(20);
      check("paused", {2'b00, state_o}, 4'd2);
      press_pause();
      check("resumed", {2'b00, state_o}, 4'd1);

      // ADJUST: minutes, then seconds, pause ignored, exit to PAUSED.
      sw_adj = 1'b1; sw_sel = 1'b0;
      run(25);
      check("adjust", {2'b00, state_o}, 4'd3);
      sw_sel = 1'b1;
      run(25);
      press_pause();
      check("adj_pause_ign", {2'b00, state_o}, 4'd3);
      sw_adj = 1'b0;
      run(12);
      check("adj_exit", {2'b00, state_o}, 4'd2);

      // Reset press coinciding with a 1 Hz tick in RUN.
      press_pause();
      btn_reset = 1'b1;
      hit = 0;
      for (int k = 0; k < 12; k++) begin
         if (k == 8) btn_reset = 1'b0;
         tick_1hz = m_rise[0];
         tick_2hz = 1'b0;
         cyc();
         if (tick_1hz) begin
            hit = 1;
            check("rst_tick_clr", {3'b0, cnt_clr}, 4'h1);
            check("rst_tick_inc", {3'b0, cnt_inc_sec}, 4'h0);
         end
      end
      tick_1hz = 1'b0;
      check("rst_tick_seen", {3'b0, hit}, 4'h1);
      check("rst_to_idle", {2'b00, state_o}, 4'd0);

      // Async reset mid-RUN with a pause press half debounced.
      press_pause();
      btn_pause = 1'b1;
      run(4);
      #1 RESET_N = 1'b0;
      #1;
      check("async_state", {2'b00, state_o}, 4'h0);
      check("async_carry", {3'b0, cnt_carry_en}, 4'h0);
      check("async_inc", {2'b0, cnt_inc_sec, cnt_inc_min}, 4'h0);
      model_reset();
      btn_pause = 1'b0;
      @(negedge clk);
      @(negedge clk);
      RESET_N = 1'b1;
      run(20);
      check("post_reset_idle", {2'b00, state_o}, 4'd0);

      // Randomized operation: slow-changing buttons/switches, random ticks.
      for (int k = 0; k < 2500; k++) begin
         if ($urandom_range(0, 11) == 0) btn_reset = ~btn_reset;
         if ($urandom_range(0, 7) == 0)  btn_pause = ~btn_pause;
         if ($urandom_range(0, 39) == 0) sw_adj = ~sw_adj;
         if ($urandom_range(0, 15) == 0) sw_sel = ~sw_sel;
         // Occasional short bounces.
         if ($urandom_range(0, 29) == 0) btn_pause = ~btn_pause;
         rnd_ticks();
         cyc();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
